// File: rtl/dcache_load_responder_if.sv
`default_nettype none
// dcache_load_responder_if: load request/response, memory handshake and fill
// broadcast for the data cache load responder.
interface dcache_load_responder_if #(
  parameter int NUM_MSHRS = 4,
  parameter int MSHR_W    = $clog2(NUM_MSHRS)
);
  logic                   load_req_valid;
  logic [31:0]            load_req_addr;
  // LOAD_DATA_CACHE_PACKET
  logic                   pkt_valid;
  logic [1:0][31:0]       pkt_data;
  logic [1:0][3:0]        pkt_byte_mask;
  logic [MSHR_W-1:0]      pkt_mshr_idx;

  logic                   mem_req_valid;
  logic [31:0]            mem_req_addr;
  logic [MSHR_W-1:0]      mem_req_tag;
  logic                   mem_req_ready;
  logic                   mem_resp_valid;
  logic [MSHR_W-1:0]      mem_resp_tag;
  logic [63:0]            mem_resp_data;

  logic                   fill_valid;
  logic [MSHR_W-1:0]      fill_mshr_idx;
  logic [63:0]            fill_data;

  modport slave (
    input  load_req_valid, load_req_addr, mem_req_ready,
    input  mem_resp_valid, mem_resp_tag, mem_resp_data,
    output pkt_valid, pkt_data, pkt_byte_mask, pkt_mshr_idx,
    output mem_req_valid, mem_req_addr, mem_req_tag,
    output fill_valid, fill_mshr_idx, fill_data
  );

  modport master (
    output load_req_valid, load_req_addr, mem_req_ready,
    output mem_resp_valid, mem_resp_tag, mem_resp_data,
    input  pkt_valid, pkt_data, pkt_byte_mask, pkt_mshr_idx,
    input  mem_req_valid, mem_req_addr, mem_req_tag,
    input  fill_valid, fill_mshr_idx, fill_data
  );
endinterface
`default_nettype wire

// File: rtl/dcache_load_responder.sv
`default_nettype none
// dcache_load_responder: direct-mapped read-only line array with an MSHR file,
// zero-latency load response and a registered fill broadcast.
module dcache_load_responder #(
  parameter int NUM_SETS  = 32,
  parameter int NUM_MSHRS = 4,
  parameter int MSHR_W    = $clog2(NUM_MSHRS)
) (
  input wire                     clock,
  input wire                     reset,
  dcache_load_responder_if.slave bus
);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int LINE_W = 29;
  localparam int TAG_W  = LINE_W - SET_W;

  localparam logic [1:0] S_FREE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;

  logic [NUM_SETS-1:0] r_line_valid;
  logic [TAG_W-1:0]    r_line_tag  [NUM_SETS];
  logic [63:0]         r_line_data [NUM_SETS];

  logic [1:0]          r_mshr_state     [NUM_MSHRS];
  logic [1:0]          w_mshr_state_nxt [NUM_MSHRS];
  logic [LINE_W-1:0]   r_mshr_line      [NUM_MSHRS];

  logic                r_issue_lock;
  logic [MSHR_W-1:0]   r_issue_lock_idx;
  logic                r_fill_valid;
  logic [MSHR_W-1:0]   r_fill_idx;
  logic [63:0]         r_fill_data;

  logic [LINE_W-1:0]   w_req_line;
  logic [SET_W-1:0]    w_req_set;
  logic [TAG_W-1:0]    w_req_tag;
  logic                w_unused_offset;
  logic                w_hit;
  logic                w_merge;
  logic [MSHR_W-1:0]   w_merge_idx;
  logic                w_free_any;
  logic [MSHR_W-1:0]   w_free_idx;
  logic                w_pend_any;
  logic [MSHR_W-1:0]   w_pend_idx;
  logic                w_alloc;
  logic [MSHR_W-1:0]   w_issue_idx;
  logic                w_fill;
  logic [LINE_W-1:0]   w_fill_line;

  assign w_req_line      = bus.load_req_addr[31:3];
  assign w_req_set       = w_req_line[SET_W-1:0];
  assign w_req_tag       = w_req_line[LINE_W-1:SET_W];
  assign w_unused_offset = ^bus.load_req_addr[2:0];

  // Downward scans so the lowest matching index wins.
  always_comb begin
    w_hit       = r_line_valid[w_req_set] && (r_line_tag[w_req_set] == w_req_tag);
    w_merge     = 1'b0;
    w_merge_idx = '0;
    w_free_any  = 1'b0;
    w_free_idx  = '0;
    w_pend_any  = 1'b0;
    w_pend_idx  = '0;
    for (int i = NUM_MSHRS - 1; i >= 0; i--) begin
      if ((r_mshr_state[i] != S_FREE) && (r_mshr_line[i] == w_req_line)) begin
        w_merge     = 1'b1;
        w_merge_idx = MSHR_W'(i);
      end
      if (r_mshr_state[i] == S_FREE) begin
        w_free_any = 1'b1;
        w_free_idx = MSHR_W'(i);
      end
      if (r_mshr_state[i] == S_PENDING) begin
        w_pend_any = 1'b1;
        w_pend_idx = MSHR_W'(i);
      end
    end
  end

  assign w_alloc     = bus.load_req_valid && !w_hit && !w_merge && w_free_any;
  // A refused request stays locked so addr/tag cannot change under the requester.
  assign w_issue_idx = r_issue_lock ? r_issue_lock_idx : w_pend_idx;
  assign w_fill      = bus.mem_resp_valid && (r_mshr_state[bus.mem_resp_tag] == S_WAIT);
  assign w_fill_line = r_mshr_line[bus.mem_resp_tag];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_MSHRS; i++) r_mshr_state[i] <= S_FREE;
      r_issue_lock     <= 1'b0;
      r_issue_lock_idx <= '0;
    end else begin
      for (int i = 0; i < NUM_MSHRS; i++) r_mshr_state[i] <= w_mshr_state_nxt[i];
      r_issue_lock     <= w_pend_any && !bus.mem_req_ready;
      r_issue_lock_idx <= w_issue_idx;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_MSHRS; i++) begin
      w_mshr_state_nxt[i] = r_mshr_state[i];
      case (r_mshr_state[i])
        S_FREE:    if (w_alloc && (w_free_idx == MSHR_W'(i))) w_mshr_state_nxt[i] = S_PENDING;
        S_PENDING: if (w_pend_any && bus.mem_req_ready && (w_issue_idx == MSHR_W'(i)))
                     w_mshr_state_nxt[i] = S_WAIT;
        S_WAIT:    if (bus.mem_resp_valid && (bus.mem_resp_tag == MSHR_W'(i)))
                     w_mshr_state_nxt[i] = S_FREE;
        default:   w_mshr_state_nxt[i] = S_FREE;
      endcase
    end
  end

  always_comb begin
    bus.pkt_valid     = 1'b0;
    bus.pkt_data      = '0;
    bus.pkt_byte_mask = '0;
    bus.pkt_mshr_idx  = '0;
    if (bus.load_req_valid) begin
      if (w_hit) begin
        bus.pkt_valid     = 1'b1;
        bus.pkt_data      = r_line_data[w_req_set];
        bus.pkt_byte_mask = '1;
      end else if (w_merge) begin
        bus.pkt_valid    = 1'b1;
        bus.pkt_mshr_idx = w_merge_idx;
      end else if (w_free_any) begin
        bus.pkt_valid    = 1'b1;
        bus.pkt_mshr_idx = w_free_idx;
      end
    end
    bus.mem_req_valid = w_pend_any;
    bus.mem_req_addr  = w_pend_any ? {r_mshr_line[w_issue_idx], 3'b000} : '0;
    bus.mem_req_tag   = w_pend_any ? w_issue_idx : '0;
    bus.fill_valid    = r_fill_valid;
    bus.fill_mshr_idx = r_fill_idx;
    bus.fill_data     = r_fill_data;
  end

  // Line address is only meaningful while the MSHR is non-FREE, so no reset.
  always_ff @(posedge clock) begin
    if (w_alloc) r_mshr_line[w_free_idx] <= w_req_line;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_line_valid <= '0;
      r_fill_valid <= 1'b0;
      r_fill_idx   <= '0;
      r_fill_data  <= '0;
    end else begin
      r_fill_valid <= w_fill;
      if (w_fill) begin
        r_line_valid[w_fill_line[SET_W-1:0]] <= 1'b1;
        r_fill_idx                           <= bus.mem_resp_tag;
        r_fill_data                          <= bus.mem_resp_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_line_tag[w_fill_line[SET_W-1:0]]  <= w_fill_line[LINE_W-1:SET_W];
      r_line_data[w_fill_line[SET_W-1:0]] <= bus.mem_resp_data;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dcache_load_responder.sv
`default_nettype none
// tb_dcache_load_responder: table-driven vectors with a fill scoreboard.
module tb_dcache_load_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dcache_load_responder_if #(.NUM_MSHRS(4)) bus ();

  dcache_load_responder #(.NUM_SETS(32), .NUM_MSHRS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          rst;
    bit          req_v;
    logic [31:0] addr;
    bit          rdy;
    bit          resp_v;
    logic [1:0]  tag;
    logic [63:0] data;
    bit          ev;
    bit          eh;
    logic [1:0]  eidx;
    logic [63:0] edata;
    bit          mv;
    logic [31:0] maddr;
    logic [1:0]  mtag;
  } vec_t;

  typedef struct packed {
    logic [1:0]  tag;
    logic [63:0] data;
  } fill_t;

  fill_t sb[$];
  int    n_vec  = 0;
  int    n_err  = 0;
  int    n_cmp  = 0;
  bit    mon_en = 1'b0;

  localparam logic [63:0] D1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D3 = 64'hA5A5_0303_5A5A_3030;
  localparam logic [63:0] D5 = 64'hCAFE_F00D_0123_4567;
  localparam logic [63:0] DX = 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int rst, int rv, int a, int rdy, int pv, int tag,
                              logic [63:0] d, int ev, int eh, int eidx,
                              logic [63:0] ed, int mv, int ma, int mt);
    vec_t v;
    v.rst = (rst != 0);   v.req_v = (rv != 0);   v.addr  = 32'(a);
    v.rdy = (rdy != 0);   v.resp_v = (pv != 0);  v.tag   = 2'(tag);
    v.data = d;           v.ev = (ev != 0);      v.eh    = (eh != 0);
    v.eidx = 2'(eidx);    v.edata = ed;          v.mv    = (mv != 0);
    v.maddr = 32'(ma);    v.mtag = 2'(mt);
    return v;
  endfunction

  task automatic idle_inputs();
    bus.load_req_valid = 1'b0; bus.load_req_addr = '0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_tag  = '0; bus.mem_resp_data = '0;
  endtask

  // Asynchronous reset asserted and released away from clock edges.
  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b0;
    idle_inputs();
    #2;
    chk("rst_fill_valid", 64'(bus.fill_valid), 64'd0);
    chk("rst_fill_idx", 64'(bus.fill_mshr_idx), 64'd0);
    chk("rst_fill_data", bus.fill_data, 64'd0);
    chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_pkt_valid", 64'(bus.pkt_valid), 64'd0);
    chk("rst_pkt_mask", 64'(bus.pkt_byte_mask), 64'd0);
    chk("rst_pkt_data", 64'(bus.pkt_data), 64'd0);
    chk("rst_pkt_idx", 64'(bus.pkt_mshr_idx), 64'd0);
    @(posedge clock); #2;
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic apply(input vec_t v, input bit push_fill);
    if (v.rst) do_reset();
    @(posedge clock); #1;
    bus.load_req_valid = v.req_v;  bus.load_req_addr = v.addr;
    bus.mem_req_ready  = v.rdy;
    bus.mem_resp_valid = v.resp_v; bus.mem_resp_tag  = v.tag;
    bus.mem_resp_data  = v.data;
    if (v.resp_v && push_fill) sb.push_back('{v.tag, v.data});
    n_vec++;
    @(negedge clock);
    chk("pkt_valid", 64'(bus.pkt_valid), 64'(v.ev));
    chk("pkt_byte_mask", 64'(bus.pkt_byte_mask), v.eh ? 64'hFF : 64'h0);
    chk("pkt_mshr_idx", 64'(bus.pkt_mshr_idx), 64'(v.eidx));
    chk("pkt_data", 64'(bus.pkt_data), v.eh ? v.edata : 64'h0);
    chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(v.mv));
    if (v.mv) begin
      chk("mem_req_addr", 64'(bus.mem_req_addr), 64'(v.maddr));
      chk("mem_req_tag", 64'(bus.mem_req_tag), 64'(v.mtag));
    end
  endtask

  // Every fill broadcast must match the oldest response the bench expects.
  always @(negedge clock) begin
    if (mon_en && bus.fill_valid) begin
      if (sb.size() == 0) begin
        chk("fill_unexpected", 64'(bus.fill_valid), 64'd0);
      end else begin
        fill_t f;
        f = sb.pop_front();
        chk("fill_mshr_idx", 64'(bus.fill_mshr_idx), 64'(f.tag));
        chk("fill_data", bus.fill_data, f.data);
      end
    end
  end

  initial begin
    vec_t tbl[$];
    idle_inputs();
    //        rst rv addr   rdy pv tg data  ev eh ix edata mv maddr  mt
    // Miss, issue, fill, then hit.
    tbl.push_back(mk(1, 1, 'h104, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0,     0));
    tbl.push_back(mk(0, 0, 0,     1, 0, 0, 0,  0, 0, 0, 0,  1, 'h100, 0));
    tbl.push_back(mk(0, 0, 0,     0, 1, 0, D1, 0, 0, 0, 0,  0, 0,     0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0,  0, 0, 0, 0,  0, 0,     0));
    tbl.push_back(mk(0, 1, 'h104, 0, 0, 0, 0,  1, 1, 0, D1, 0, 0,     0));
    // Secondary miss merges; a single memory request.
    tbl.push_back(mk(0, 1, 'h200, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0,     0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0,  0, 0, 0, 0,  1, 'h200, 0));
    tbl.push_back(mk(0, 1, 'h204, 0, 0, 0, 0,  1, 0, 0, 0,  1, 'h200, 0));
    tbl.push_back(mk(0, 0, 0,     1, 0, 0, 0,  0, 0, 0, 0,  1, 'h200, 0));
    tbl.push_back(mk(0, 0, 0,     1, 0, 0, 0,  0, 0, 0, 0,  0, 0,     0));
    // Fill the MSHR file, full stall, reallocation after response.
    tbl.push_back(mk(1, 1, 'h100, 1, 0, 0, 0,  1, 0, 0, 0,  0, 0,     0));
    tbl.push_back(mk(0, 1, 'h200, 1, 0, 0, 0,  1, 0, 1, 0,  1, 'h100, 0));
    tbl.push_back(mk(0, 1, 'h300, 1, 0, 0, 0,  1, 0, 2, 0,  1, 'h200, 1));
    tbl.push_back(mk(0, 1, 'h400, 1, 0, 0, 0,  1, 0, 3, 0,  1, 'h300, 2));
    tbl.push_back(mk(0, 1, 'h500, 1, 0, 0, 0,  0, 0, 0, 0,  1, 'h400, 3));
    tbl.push_back(mk(0, 1, 'h500, 1, 1, 2, D3, 0, 0, 0, 0,  0, 0,     0));
    tbl.push_back(mk(0, 1, 'h500, 1, 0, 0, 0,  1, 0, 2, 0,  0, 0,     0));
    // Request in the response cycle merges, then hits in the fill cycle.
    tbl.push_back(mk(1, 1, 'h600, 1, 0, 0, 0,  1, 0, 0, 0,  0, 0,     0));
    tbl.push_back(mk(0, 1, 'h700, 1, 0, 0, 0,  1, 0, 1, 0,  1, 'h600, 0));
    tbl.push_back(mk(0, 1, 'h800, 1, 0, 0, 0,  1, 0, 2, 0,  1, 'h700, 1));
    tbl.push_back(mk(0, 1, 'h100, 1, 0, 0, 0,  1, 0, 3, 0,  1, 'h800, 2));
    tbl.push_back(mk(0, 0, 0,     1, 0, 0, 0,  0, 0, 0, 0,  1, 'h100, 3));
    tbl.push_back(mk(0, 1, 'h104, 1, 1, 3, D5, 1, 0, 3, 0,  0, 0,     0));
    tbl.push_back(mk(0, 1, 'h104, 1, 0, 0, 0,  1, 1, 0, D5, 0, 0,     0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b1);

    // Back-pressure: MSHR 0 request held stable, then MSHR 1 follows.
    apply(mk(1, 1, 'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,     0), 1'b1);
    apply(mk(0, 1, 'h200, 0, 0, 0, 0, 1, 0, 1, 0, 1, 'h100, 0), 1'b1);
    for (int k = 0; k < 5; k++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h100, 0), 1'b1);
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h100, 0), 1'b1);
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h200, 1), 1'b1);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0), 1'b1);

    // Reset while MSHR 1 waits; its late response must be dropped.
    apply(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0), 1'b1);
    apply(mk(0, 0, 0, 0, 1, 1, DX, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    apply(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0), 1'b1);
    chk("fill_after_stale_resp", 64'(bus.fill_valid), 64'd0);
    apply(mk(0, 1, 'h200, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1);

    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    chk("fill_queue_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dcache_load_responder.md
Name: dcache_load_responder

Overview:
- Cache-side responder for the load data stage's request port.
- Accepts a same-cycle load request (address only) and answers combinationally with a LOAD_DATA_CACHE_PACKET:
  - hit: full line data, all byte-mask bits set;
  - miss: an MSHR index for the load buffer to wait on.
- Owns a direct-mapped, read-only line array, an MSHR file, the memory request/response handshake, and a registered fill broadcast that wakes pending loads.

Parameters:
- NUM_SETS, 32, lines in direct-mapped array; line = 8 bytes (2 words).
- NUM_MSHRS, 4, outstanding line misses.
- MSHR_W, $clog2(NUM_MSHRS), MSHR index width.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- load_req_valid  in  1  load request this cycle.
- load_req_addr  in  ADDR(32)  byte address; [2]=w_idx, [7:3]=set, [31:8]=tag.
- load_data_cache_packet  out  LOAD_DATA_CACHE_PACKET  valid, data[2], byte_mask[2][4], mshr_idx.
- mem_req_valid  out  1  line fetch request.
- mem_req_addr  out  ADDR(32)  line-aligned address ([2:0]=0).
- mem_req_tag  out  MSHR_W  issuing MSHR index.
- mem_req_ready  in  1  memory accepts request this cycle.
- mem_resp_valid  in  1  line data returning.
- mem_resp_tag  in  MSHR_W  MSHR index of returning line.
- mem_resp_data  in  64  line data, word0 = bits [31:0].
- fill_valid  out  1  registered pulse: MSHR completed.
- fill_mshr_idx  out  MSHR_W  completed MSHR.
- fill_data  out  64  completed line data.

Behaviour:
- Reset (asynchronous, reset==0):
  - all line valid bits cleared; all MSHRs FREE;
  - fill_valid=0, fill_mshr_idx=0, fill_data=0, mem_req_valid=0;
  - packet valid=0, byte_mask=0, data=0, mshr_idx=0.
  - Reset mid-miss drops the MSHR; a later mem_resp carrying a stale tag is ignored because that MSHR is FREE.
- Response is combinational from registered state, zero latency. Priority:
  1. Hit: line valid && tag match -> valid=1, data=line, byte_mask=all ones (both words), mshr_idx=0.
  2. Merge: miss && a non-FREE MSHR holds the same line address -> valid=1, byte_mask=0, mshr_idx=that MSHR. No allocation.
  3. Allocate: miss, no match, at least one FREE MSHR -> valid=1, byte_mask=0, mshr_idx=lowest-index FREE MSHR. That MSHR becomes PENDING at the clock edge, recording the line address.
  4. Full: no FREE MSHR -> valid=0. The requester holds and retries.
- load_req_valid=0 -> packet valid=0, byte_mask=0, and no state change.
- Per-MSHR state machine:
  - FREE -> PENDING on allocate.
  - PENDING -> WAIT when selected for issue and mem_req_ready=1.
  - WAIT -> FREE when mem_resp_valid && mem_resp_tag matches this MSHR.
  - A mem_resp targeting a FREE or PENDING MSHR is ignored.
- Issue:
  - mem_req_valid=1 iff any MSHR is PENDING; the lowest-index PENDING MSHR is selected.
  - mem_req_addr and mem_req_tag are held stable until accepted.
- Fill, at the edge of the mem_resp cycle:
  - line array[set] written with data, tag and valid=1; the existing line is overwritten (array is clean, no writeback).
  - fill_valid=1, fill_mshr_idx=tag, fill_data=mem_resp_data, registered.
  - fill_valid is low in every other cycle.
- Simultaneous events:
  - A request to a line in the same cycle its mem_resp arrives merges (returns the MSHR index). The load buffer captures that index at the same edge the fill is broadcast next cycle, so no wakeup is lost.
  - A request in the fill_valid cycle hits the freshly written line.
  - A freed MSHR can be reallocated only from the next cycle; it is not reallocated in the mem_resp cycle.
  - Allocate plus issue of a different MSHR in one cycle are both permitted.
  - A new allocation is not issued in its own allocation cycle.
- Branch squash is not visible here: an MSHR for a squashed load still completes and broadcasts. Consumers discard fills with no waiting entry.
- Stores do not touch this block; store data reaches loads only via store-queue forwarding.

Test Plan:
1. Reset, then request addr 0x0000_0104 -> valid=1, byte_mask=0, mshr_idx=0.
   - Next cycle: mem_req_valid=1, addr 0x0000_0100, tag 0; assert mem_req_ready.
   - mem_resp tag 0, data 0x1122_3344_5566_7788 -> next cycle fill_valid=1, idx 0.
   - Request 0x104 again -> hit, data[1]=0x1122_3344, byte_mask all ones.
2. Miss 0x200, then 0x204 two cycles later with no mem response -> second request returns the same mshr_idx=0; only one mem_req is issued.
3. Misses to 0x100, 0x200, 0x300, 0x400 on consecutive cycles -> idx 0..3.
   - Fifth miss 0x500 -> valid=0.
   - Return tag 2 -> 0x500 is accepted the cycle after the response with idx 2.
4. Hold mem_req_ready=0 for 5 cycles with MSHRs 0 and 1 PENDING -> addr/tag of MSHR 0 stable throughout; on ready, MSHR 1 is issued next.
5. Request 0x104 in the same cycle as the mem_resp for its MSHR 3 -> merge, mshr_idx=3, then fill_valid with idx 3. Request again in the fill_valid cycle -> hit.
6. Assert reset low while MSHR 1 is in WAIT, release, then send mem_resp tag 1 -> no fill_valid, line stays invalid, request misses and allocates idx 0.
